// File: rtl/vga_timing_pkg.sv
// Shared helpers for the VGA raster timing generator: totals, counter widths
// and the registered sync/enable output bundle.
package vga_timing_pkg;

    // Pixels per line including porches and sync.
    function automatic int htotal(input int hdisp, input int hfp,
                                  input int hpulse, input int hbp);
        return hdisp + hfp + hpulse + hbp;
    endfunction

    // Lines per frame including porches and sync.
    function automatic int vtotal(input int vdisp, input int vfp,
                                  input int vpulse, input int vbp);
        return vdisp + vfp + vpulse + vbp;
    endfunction

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Registered single-bit timing outputs.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic sol;
        logic sof;
    } timing_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter with a terminal-count flag; holds when en_i is low.
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // wrap_o marks the last count; the counter rolls to 0 on the next enabled clock.
    assign wrap_o = (cnt_q == W'(MAX - 1));
    assign cnt_o  = cnt_q;

    // Next count: advance when enabled, roll over at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator with programmable porches,
// sync polarity, clock enable, frame counter and a look-ahead fetch request.
// Every output is registered and describes the counter position one clock earlier.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int HDISP     = 640,
    parameter int HFP       = 16,
    parameter int HPULSE    = 96,
    parameter int HBP       = 48,
    parameter int VDISP     = 480,
    parameter int VFP       = 10,
    parameter int VPULSE    = 2,
    parameter int VBP       = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 2,
    parameter int FCW       = 8,
    localparam int HTOTAL   = htotal(HDISP, HFP, HPULSE, HBP),
    localparam int VTOTAL   = vtotal(VDISP, VFP, VPULSE, VBP),
    localparam int HW       = cnt_width(HTOTAL),
    localparam int VW       = cnt_width(VTOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           hs,
    output logic           vs,
    output logic           de,
    output logic [HW-1:0]  x,
    output logic [VW-1:0]  y,
    output logic           sol,
    output logic           sof,
    output logic           req,
    output logic [HW-1:0]  req_x,
    output logic [VW-1:0]  req_y,
    output logic [FCW-1:0] frame_cnt
);

    if (HDISP <= 0 || HFP <= 0 || HPULSE <= 0 || HBP <= 0 ||
        VDISP <= 0 || VFP <= 0 || VPULSE <= 0 || VBP <= 0) begin : g_bad_timing
        $error("vga_timing_gen: display, porch and pulse lengths must all be non-zero");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD >= HTOTAL) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must lie in 0..HTOTAL-1");
    end

    localparam timing_t TIM_RST = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0, sol: 1'b0, sof: 1'b0};

    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           h_wrap, v_wrap;

    // Line counter advances every enabled clock; frame counter once per line.
    wrap_counter #(.MAX(HTOTAL), .W(HW)) u_hcnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .cnt_o  (hcnt),
        .wrap_o (h_wrap)
    );

    wrap_counter #(.MAX(VTOTAL), .W(VW)) u_vcnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en && h_wrap),
        .cnt_o  (vcnt),
        .wrap_o (v_wrap)
    );

    logic [FCW-1:0] fcnt_q, fcnt_d;
    timing_t        tim_q, tim_d;
    logic [HW-1:0]  x_q, rx_d, rx_q;
    logic [VW-1:0]  y_q, ry_d, ry_q;
    logic           req_d, req_q;
    logic [FCW-1:0] frame_q;
    logic [HW:0]    la_pos;

    // Completed-frame count bumps when the last pixel of the last line is consumed.
    always_comb begin
        fcnt_d = fcnt_q;
        if (en && h_wrap && v_wrap) fcnt_d = fcnt_q + 1'b1;
    end

    // Decode the current position and the look-ahead position into next outputs.
    always_comb begin
        tim_d     = TIM_RST;
        tim_d.de  = (hcnt < HW'(HDISP)) && (vcnt < VW'(VDISP));
        tim_d.hs  = (hcnt >= HW'(HDISP + HFP) && hcnt < HW'(HDISP + HFP + HPULSE))
                    ? HS_POL : !HS_POL;
        tim_d.vs  = (vcnt >= VW'(VDISP + VFP) && vcnt < VW'(VDISP + VFP + VPULSE))
                    ? VS_POL : !VS_POL;
        tim_d.sol = (hcnt == '0);
        tim_d.sof = (hcnt == '0) && (vcnt == '0);

        // Fetch position runs LOOKAHEAD pixels ahead, spilling into the next line/frame.
        la_pos = {1'b0, hcnt} + (HW+1)'(LOOKAHEAD);
        if (la_pos < (HW+1)'(HTOTAL)) begin
            rx_d = la_pos[HW-1:0];
            ry_d = vcnt;
        end else begin
            rx_d = HW'(la_pos - (HW+1)'(HTOTAL));
            ry_d = v_wrap ? '0 : vcnt + 1'b1;
        end
        req_d = (rx_d < HW'(HDISP)) && (ry_d < VW'(VDISP));
    end

    // Output and frame-count registers; everything holds while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            frame_q <= '0;
            tim_q   <= TIM_RST;
            x_q     <= '0;
            y_q     <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            req_q   <= 1'b0;
        end else if (en) begin
            fcnt_q  <= fcnt_d;
            frame_q <= fcnt_q;
            tim_q   <= tim_d;
            x_q     <= hcnt;
            y_q     <= vcnt;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            req_q   <= req_d;
        end
    end

    assign hs        = tim_q.hs;
    assign vs        = tim_q.vs;
    assign de        = tim_q.de;
    assign sol       = tim_q.sol;
    assign sof       = tim_q.sof;
    assign x         = x_q;
    assign y         = y_q;
    assign req       = req_q;
    assign req_x     = rx_q;
    assign req_y     = ry_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small 8x6 raster (look-ahead 2, 2-bit frame
// counter) and a 160x90 raster with inverted sync polarity, both compared
// against a position-arithmetic reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT A: 4x3 visible, HTOTAL=8, VTOTAL=6 ----------------
    logic       rst_a, en_a;
    logic       a_hs, a_vs, a_de, a_sol, a_sof, a_req;
    logic [2:0] a_x, a_rx;
    logic [2:0] a_y, a_ry;
    logic [1:0] a_fc;
    logic [19:0] obs_a;
    assign obs_a = {a_hs, a_vs, a_de, a_sol, a_sof, a_x, a_y, a_req, a_rx, a_ry, a_fc};

    vga_timing_gen #(
        .HDISP(4), .HFP(1), .HPULSE(2), .HBP(1),
        .VDISP(3), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(2), .FCW(2)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .hs(a_hs), .vs(a_vs), .de(a_de), .x(a_x), .y(a_y),
        .sol(a_sol), .sof(a_sof), .req(a_req), .req_x(a_rx), .req_y(a_ry),
        .frame_cnt(a_fc)
    );

    // ---------------- DUT B: 160x90, default porches, active-high syncs ------
    logic       rst_b, en_b;
    logic       b_hs, b_vs, b_de, b_sol, b_sof, b_req;
    logic [8:0] b_x, b_rx;
    logic [7:0] b_y, b_ry;
    logic [7:0] b_fc;
    logic [47:0] obs_b;
    assign obs_b = {b_hs, b_vs, b_de, b_sol, b_sof, b_x, b_y, b_req, b_rx, b_ry, b_fc};

    vga_timing_gen #(
        .HDISP(160), .HFP(16), .HPULSE(96), .HBP(48),
        .VDISP(90), .VFP(10), .VPULSE(2), .VBP(33),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(0), .FCW(8)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .hs(b_hs), .vs(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .sol(b_sol), .sof(b_sof), .req(b_req), .req_x(b_rx), .req_y(b_ry),
        .frame_cnt(b_fc)
    );

    // ---------------- reference model ----------------
    // n = enabled clock edges since reset; outputs describe raster position n-1.
    int na = 0;
    int nb = 0;
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) na = 0;
        else if (en_a) na = na + 1;
    end
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) nb = 0;
        else if (en_b) nb = nb + 1;
    end

    typedef struct {
        int hs, vs, de, sol, sof, x, y, req, rx, ry, fc;
    } exp_t;

    function automatic exp_t model(input int n, input int hd, input int hfp, input int hp,
                                   input int hbp, input int vd, input int vfp, input int vp,
                                   input int vbp, input int hpol, input int vpol,
                                   input int la, input int fcw);
        exp_t e;
        int ht, vt, per, k, h, v, idx;
        ht  = hd + hfp + hp + hbp;
        vt  = vd + vfp + vp + vbp;
        per = ht * vt;
        e   = '{hs: 1 - hpol, vs: 1 - vpol, default: 0};
        if (n == 0) return e;
        k     = n - 1;
        h     = k % ht;
        v     = (k / ht) % vt;
        e.x   = h;
        e.y   = v;
        e.de  = (h < hd && v < vd) ? 1 : 0;
        e.hs  = (h >= hd + hfp && h < hd + hfp + hp) ? hpol : 1 - hpol;
        e.vs  = (v >= vd + vfp && v < vd + vfp + vp) ? vpol : 1 - vpol;
        e.sol = (h == 0) ? 1 : 0;
        e.sof = (h == 0 && v == 0) ? 1 : 0;
        idx   = (k % per + la) % per;
        e.rx  = idx % ht;
        e.ry  = idx / ht;
        e.req = (e.rx < hd && e.ry < vd) ? 1 : 0;
        e.fc  = (k / per) % (1 << fcw);
        return e;
    endfunction

    function automatic logic [19:0] exp_a(input int n);
        exp_t e;
        e = model(n, 4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 2, 2);
        return {e.hs[0], e.vs[0], e.de[0], e.sol[0], e.sof[0], e.x[2:0], e.y[2:0],
                e.req[0], e.rx[2:0], e.ry[2:0], e.fc[1:0]};
    endfunction

    function automatic logic [47:0] exp_b(input int n);
        exp_t e;
        e = model(n, 160, 16, 96, 48, 90, 10, 2, 33, 1, 1, 0, 8);
        return {e.hs[0], e.vs[0], e.de[0], e.sol[0], e.sof[0], e.x[8:0], e.y[7:0],
                e.req[0], e.rx[8:0], e.ry[7:0], e.fc[7:0]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs_a !== exp_a(na)) begin
            fails++; $display("FAIL reset_a got %h exp %h", obs_a, exp_a(na));
        end
        tests++;
        if (obs_b !== exp_b(nb)) begin
            fails++; $display("FAIL reset_b got %h exp %h", obs_b, exp_b(nb));
        end
        en_a = 1'b1; en_b = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({a_hs, a_vs, a_de, a_sof, a_req, a_x, a_fc} !== 10'b11_000_000_00) begin
            fails++; $display("FAIL reset_hold_a got %b", {a_hs, a_vs, a_de, a_sof, a_req, a_x, a_fc});
        end
        tests++;
        if ({b_hs, b_vs, b_de, b_sof} !== 4'b0000) begin
            fails++; $display("FAIL reset_pol_b got %b exp 0000", {b_hs, b_vs, b_de, b_sof});
        end
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (obs_a !== exp_a(na)) begin
            fails++; $display("FAIL release_idle_a got %h exp %h", obs_a, exp_a(na));
        end
        en_a = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({a_sof, a_sol, a_de, a_x, a_y} !== 9'b111_000_000) begin
            fails++; $display("FAIL first_pixel got %b exp 111000000", {a_sof, a_sol, a_de, a_x, a_y});
        end
        tests++;
        if (obs_a !== exp_a(na)) begin
            fails++; $display("FAIL first_pixel_model got %h exp %h", obs_a, exp_a(na));
        end
        en_a = 1'b0;
    endtask

    task automatic test_raster_lookahead();
        logic rq[$];
        rst_a = 1'b1; @(posedge clk); #1;
        rst_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs_a !== exp_a(na)) begin
                fails++; $display("FAIL raster_a n=%0d got %h exp %h", na, obs_a, exp_a(na));
            end
            rq.push_back(a_req);
            if (i >= 2) begin
                tests++;
                if (a_de !== rq[i-2]) begin
                    fails++; $display("FAIL req_lead n=%0d de %b req_2_ago %b", na, a_de, rq[i-2]);
                end
            end
            if (a_x == 3'd7 && a_y == 3'd2) begin
                tests++;
                if ({a_req, a_rx, a_ry} !== {1'b0, 3'd1, 3'd3}) begin
                    fails++; $display("FAIL line_wrap_req got %b exp 0001011", {a_req, a_rx, a_ry});
                end
            end
            if (a_x == 3'd6 && a_y == 3'd5) begin
                tests++;
                if ({a_req, a_rx, a_ry} !== {1'b1, 3'd0, 3'd0}) begin
                    fails++; $display("FAIL frame_wrap_req got %b exp 1000000", {a_req, a_rx, a_ry});
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        bit found;
        found = 1'b0;
        en_a = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs_a !== exp_a(na)) begin
                fails++; $display("FAIL seek_x2 got %h exp %h", obs_a, exp_a(na));
            end
            if (a_x == 3'd2) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL seek_x2 timeout x=%0d exp 2", a_x);
        end
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs_a !== exp_a(na) || a_x !== 3'd2) begin
                fails++; $display("FAIL freeze cyc=%0d got %h exp %h", i, obs_a, exp_a(na));
            end
        end
        en_a = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (a_x !== 3'd3 || obs_a !== exp_a(na)) begin
            fails++; $display("FAIL resume x=%0d exp 3 got %h exp %h", a_x, obs_a, exp_a(na));
        end
        for (int i = 0; i < 200; i++) begin
            en_a = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            tests++;
            if (obs_a !== exp_a(na)) begin
                fails++; $display("FAIL rand_en n=%0d got %h exp %h", na, obs_a, exp_a(na));
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit found;
        found = 1'b0;
        en_a = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (a_x == 3'd3 && a_y == 3'd1) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL seek_x3y1 timeout x=%0d y=%0d", a_x, a_y);
        end
        rst_a = 1'b1;
        #1;
        tests++;
        if (obs_a !== exp_a(0) || a_fc !== 2'd0) begin
            fails++; $display("FAIL async_reset got %h exp %h", obs_a, exp_a(0));
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        tests++;
        if (obs_a !== exp_a(na)) begin
            fails++; $display("FAIL reset_held got %h exp %h", obs_a, exp_a(na));
        end
        @(posedge clk); #1;
        tests++;
        if ({a_sof, a_x, a_y, a_fc} !== 9'b1_000_000_00 || obs_a !== exp_a(na)) begin
            fails++; $display("FAIL restart_sof got %h exp %h", obs_a, exp_a(na));
        end
    endtask

    task automatic test_frame_cnt();
        logic [1:0] seq[$];
        logic [1:0] want[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_a = 1'b1; @(posedge clk); #1;
        rst_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 245; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs_a !== exp_a(na)) begin
                fails++; $display("FAIL frames_a n=%0d got %h exp %h", na, obs_a, exp_a(na));
            end
            if (a_sof) seq.push_back(a_fc);
        end
        tests++;
        if (seq.size() != 6) begin
            fails++; $display("FAIL sof_count got %0d exp 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (seq[i] !== want[i]) begin
                    fails++; $display("FAIL frame_cnt_seq[%0d] got %0d exp %0d", i, seq[i], want[i]);
                end
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_polarity_b();
        int vs_hi, hs_hi;
        vs_hi = 0; hs_hi = 0;
        rst_b = 1'b1; @(posedge clk); #1;
        rst_b = 1'b0; en_b = 1'b1;
        for (int i = 1; i <= 43200 + 330; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs_b !== exp_b(nb)) begin
                fails++; $display("FAIL raster_b n=%0d got %h exp %h", nb, obs_b, exp_b(nb));
            end
            tests++;
            if (b_req !== b_de) begin
                fails++; $display("FAIL req_eq_de n=%0d req %b de %b", nb, b_req, b_de);
            end
            if (i <= 43200 && b_vs) vs_hi++;
            if (i <= 320 && b_hs) hs_hi++;
        end
        tests++;
        if (vs_hi != 640) begin
            fails++; $display("FAIL vs_width got %0d exp 640", vs_hi);
        end
        tests++;
        if (hs_hi != 96) begin
            fails++; $display("FAIL hs_width got %0d exp 96", hs_hi);
        end
        en_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        test_reset();
        test_raster_lookahead();
        test_enable_freeze();
        test_reset_midframe();
        test_frame_cnt();
        test_polarity_b();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/LCD raster timing generator. It replaces the fixed HDISP/VDISP timing currently hard-wired inside the fpga top, which the testbench drives with HDISP=160 and VDISP=90. It adds independent porch/pulse parameters, programmable sync polarity, a clock-enable, a per-frame counter, and a look-ahead pixel request so the SDRAM-fed pixel FIFO can be read ahead of the visible pixel. It sits between the pixel clock domain logic and vga_if.

Parameters:
HDISP, 640, visible pixels per line
HFP, 16, horizontal front porch (pixels)
HPULSE, 96, horizontal sync width
HBP, 48, horizontal back porch
VDISP, 480, visible lines per frame
VFP, 10, vertical front porch (lines)
VPULSE, 2, vertical sync width
VBP, 33, vertical back porch
HS_POL, 0, active level of hs
VS_POL, 0, active level of vs
LOOKAHEAD, 2, request lead in pixel clocks (0..HTOTAL-1)
FCW, 8, frame counter width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active high
en  in  1  advance enable; 0 freezes all state
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  display enable (visible pixel)
x  out  $clog2(HTOTAL)  current column
y  out  $clog2(VTOTAL)  current line
sol  out  1  start-of-line pulse
sof  out  1  start-of-frame pulse
req  out  1  pixel fetch request, LOOKAHEAD clocks ahead of de
req_x  out  $clog2(HTOTAL)  column being requested
req_y  out  $clog2(VTOTAL)  line being requested
frame_cnt  out  FCW  completed-frame count

Behaviour:
- HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP.
- Internal counters hcnt in 0..HTOTAL-1 and vcnt in 0..VTOTAL-1. Line order: active [0,HDISP), FP, sync, BP. The same order applies vertically.
- When en=1, hcnt increments each clk. At HTOTAL-1 it wraps to 0 and vcnt increments. At vcnt=VTOTAL-1 with hcnt wrapping, vcnt wraps to 0 and frame_cnt increments modulo 2^FCW.
- When en=0, counters, frame_cnt and all outputs hold their values.
- All outputs are registered, with 1 clk latency: outputs at cycle t+1 describe the (hcnt,vcnt) held at cycle t when en=1.
- Output decode:
  - x=hcnt, y=vcnt.
  - de = (hcnt<HDISP)&&(vcnt<VDISP).
  - hs = HS_POL when hcnt in [HDISP+HFP, HDISP+HFP+HPULSE), otherwise !HS_POL.
  - vs is the same rule on vcnt with V parameters and VS_POL. vs is decoded from vcnt only, so it changes at the line boundary.
  - sol = (hcnt==0).
  - sof = (hcnt==0 && vcnt==0).
- Look-ahead: p = hcnt+LOOKAHEAD.
  - If p<HTOTAL: req_x=p, req_y=vcnt.
  - Else: req_x=p-HTOTAL, req_y=(vcnt+1) mod VTOTAL.
  - req = (req_x<HDISP)&&(req_y<VDISP).
  - Consequence: req is high exactly LOOKAHEAD clocks before de for the same (x,y), including wrap into the next line and into the next frame.
  - LOOKAHEAD=0 makes req identical to de.
- Reset (async assert, sync release inside the block is NOT added; the caller supplies a clean reset):
  - hcnt=0, vcnt=0, frame_cnt=0.
  - Outputs: de=0, req=0, sol=0, sof=0, x=0, y=0, req_x=0, req_y=0, hs=!HS_POL, vs=!VS_POL.
  - First en=1 cycle after release: next cycle shows sof=1, sol=1, de=1, x=0, y=0.
- Reset mid-frame: immediate return to the reset values listed above. The next frame starts at (0,0) with frame_cnt=0.
- Elaboration check: $error if any porch/pulse is 0, if HDISP or VDISP is 0, or if LOOKAHEAD≥HTOTAL.

Decomposition:
- Package vga_timing_pkg holds:
  - function htotal/vtotal(params);
  - localparam-computing functions for counter widths;
  - typedef struct timing_t {hs, vs, de, sol, sof} for the registered output bundle.
- One sub-module, wrap_counter #(MAX): en, wrap-out, async reset. It is instantiated twice, for h and v; the v instance is enabled by en && h_wrap.

Test Plan:
- Small timing HDISP=4,HFP=1,HPULSE=2,HBP=1,VDISP=3,VFP=1,VPULSE=1,VBP=1, en=1 → HTOTAL=8; hs low for x=5,6 (HS_POL=0); de high for 4 clocks per line on lines 0..2; sof every 48 clocks.
- Same timing with LOOKAHEAD=2 → req rises 2 clocks before de each line. At hcnt=7,vcnt=2: req_x=1, req_y=3, req=0. At hcnt=6,vcnt=5: req_y=0, req=1 (frame wrap).
- Toggle en=0 for 5 clocks mid-line at x=2 → all outputs frozen for 5 clocks, then resume at x=3 with no skipped or duplicated pixel.
- Assert rst at x=3,y=1 for 1 clock → outputs go to reset values asynchronously; frame_cnt=0. After release, sof at first enabled cycle.
- FCW=2: run 5 frames → frame_cnt sequence 1,2,3,0,1, incrementing coincident with sof.
- HS_POL=1,VS_POL=1 with 160x90 default porches → hs/vs idle low and pulse high with the widths HPULSE/VPULSE; vs pulse spans exactly VPULSE*HTOTAL clocks.
